// File: rtl/mioc_xnor_corr.sv
// mioc_xnor_corr: serial-stream correlator.
// A WIDTH-bit shift window is compared bit-by-bit (XNOR) against a
// programmable pattern under a care mask; the number of agreeing cared-for
// bits is registered as score, and a one-cycle match pulse fires when the
// armed window meets THRESH on a freshly shifted bit. Match pulses are
// counted in a saturating counter.
module mioc_xnor_corr #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned THRESH = 8,
  parameter  int unsigned CNTW   = 8,
  localparam int unsigned SW     = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              din,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [WIDTH-1:0]  mask,
  input  logic              clr,
  output logic [SW-1:0]     score,
  output logic              match,
  output logic              armed,
  output logic [CNTW-1:0]   match_cnt,
  output logic              cnt_sat
);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [SW-1:0]    fill_q, fill_d;
  logic             en_d_q;
  logic [SW-1:0]    score_q, score_d;
  logic             match_q, match_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] agree;
  logic [SW-1:0]    pop;
  logic             armed_w;

  // State register: clear returns the machine to FILL
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: arm on the shift edge where the fill count reaches WIDTH
  always_comb begin
    state_d = state_q;
    if (state_q == S_FILL && en && fill_q == SW'(WIDTH - 1)) begin
      state_d = S_ARMED;
    end
  end

  // Output decode of the state machine
  always_comb begin
    armed_w = (state_q == S_ARMED);
  end

  // Agreement vector and its population count, taken from the current window
  always_comb begin
    agree = mask & ~(sr_q ^ pattern);
    pop   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + SW'(agree[i]);
    end
  end

  // Next values for the window, fill count, score, match and counter
  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (en) begin
      sr_d = {sr_q[WIDTH-2:0], din};
      if (fill_q != SW'(WIDTH)) begin
        fill_d = fill_q + SW'(1);
      end
    end
    score_d = pop;
    match_d = armed_w & en_d_q & (|mask) & (pop >= SW'(THRESH));
    cnt_d   = cnt_q;
    if (match_d && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Datapath registers; clr shares the reset path so a coincident din is dropped
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr_q    <= '0;
      fill_q  <= '0;
      en_d_q  <= 1'b0;
      score_q <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      en_d_q  <= en;
      score_q <= score_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign score     = score_q;
  assign match     = match_q;
  assign armed     = armed_w;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: doc/mioc_xnor_corr.md
Name: mioc_xnor_corr

Overview:
- Parametrised serial-stream correlator built on per-bit XNOR agreement.
- Generalises the fixed 2-input XNOR to a WIDTH-bit masked compare between a shifting window and a programmable pattern.
- Adds a threshold match detector, a fill/arm state machine and a saturating match counter.
- Sits between a serial receive path and the control logic that reacts to sync words.

Parameters:
- WIDTH, 8, pattern/window length in bits; legal range 2..32.
- THRESH, 8, minimum number of agreeing cared-for bits for a match; legal range 1..WIDTH.
- CNTW, 8, width of the match counter; legal range 1..32.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  shift enable; din is sampled only when en=1.
- din  input  1  serial data bit.
- pattern  input  WIDTH  reference word; pattern[0] is compared with the newest bit.
- mask  input  WIDTH  1 = bit is scored, 0 = don't-care.
- clr  input  1  synchronous clear of window, fill state and counter.
- score  output  clog2(WIDTH+1)  registered count of agreeing cared-for bits.
- match  output  1  one-cycle pulse when the window meets THRESH.
- armed  output  1  high once WIDTH bits have been shifted since reset/clr.
- match_cnt  output  CNTW  saturating count of match pulses.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset (rst_n=0 at an edge) clears sr, fill, state, en_d, score, match and match_cnt to 0, and sets state to FILL. All outputs read 0 in the following cycle. Reset takes effect mid-window with no partial results retained.
- clr=1 (with rst_n=1) has the same effect as reset. clr has priority over en, so a din presented in the same cycle is discarded.
- Shift stage, on each edge with en=1: sr <= {sr[WIDTH-2:0], din}. sr[0] is the newest bit.
  - fill increments, saturating at WIDTH.
  - en_d <= en on every edge.
- State machine:
  - FILL -> ARMED on the shift edge where fill reaches WIDTH.
  - ARMED holds until reset or clr.
  - armed = (state == ARMED).
- Score stage, on every edge, from the current (already updated) sr:
  - agree[i] = mask[i] & ~(sr[i] ^ pattern[i]).
  - score <= popcount(agree).
  - score updates even in FILL, where unshifted positions compare as 0.
  - Width rule: score never overflows because its width is clog2(WIDTH+1).
- Match rule: match <= armed & en_d & (mask != 0) & (popcount(agree) >= THRESH).
  - Latency: a bit sampled at edge N can produce match high for the cycle after edge N+1.
  - At most one pulse per shifted bit. With en low, match stays 0 even if the window still matches.
  - mask = 0 never matches.
  - THRESH > popcount(mask) never matches; this is not an error.
  - Overlapping occurrences each pulse. Example: an all-ones pattern on an all-ones stream pulses on every shift once armed.
- pattern and mask are not registered. A change affects the next score-stage edge; no resynchronisation and no window flush.
- Counter: on an edge where match is being set to 1:
  - match_cnt <= match_cnt + 1 unless it is all-ones, in which case it holds.
  - cnt_sat = &match_cnt.
  - clr/reset is the only way to leave saturation.
- Simultaneous events:
  - clr with a pending match: the clear wins, and neither match nor the count increment occurs.
  - en=1 on the FILL->ARMED edge: counts as the first armed shift, so match is possible at the next edge.

Test Plan:
- WIDTH=8, THRESH=8, pattern=8'hA5, mask=8'hFF; shift 1,0,1,0,0,1,0,1 with en=1 -> armed high after the 8th shift edge, score=8, match high exactly one cycle (the cycle after edge 9), match_cnt=1.
- Same setup, then flip the 3rd bit of the stream (1,0,0,0,0,1,0,1); THRESH=7 -> score=7 and match pulses. With THRESH=8 -> score=7, match stays 0, match_cnt unchanged.
- Load pattern=8'hA5, mask=8'h0F; stream with low nibble 4'h5 and garbage high nibble -> score=4, match=1 when THRESH<=4. With mask=8'h00 -> score=0, match never asserts.
- CNTW=2, pattern=8'hFF, mask=8'hFF; stream 12 ones continuously -> matches on shifts 8..12. match_cnt goes 1,2,3,3,3 and cnt_sat rises on the 3rd match.
- Mid-stream, after 5 bits: assert clr with en=1 -> sr=0, armed=0, the discarded din is not shifted, and 8 new bits are required before any match. Repeat with rst_n=0 -> identical result, all outputs 0 the next cycle.
- Armed with a matching window, hold en=0 for 4 cycles -> match stays 0 and score stays constant. Change pattern while en=0 -> score updates at the next edge with no match pulse.
